// File: rtl/arb_pkg.sv
// Shared types and helpers for the round-robin decoder arbiter.
package arb_pkg;

    localparam int NREQ  = 16;
    localparam int SEL_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } state_t;

    // Pointer width matches NREQ exactly, so natural overflow is the mod-16 wrap.
    function automatic logic [SEL_W-1:0] ptr_inc(input logic [SEL_W-1:0] p);
        return p + 1'b1;
    endfunction

    function automatic logic [NREQ-1:0] sel_onehot(input logic [SEL_W-1:0] s);
        return NREQ'(1) << s;
    endfunction

endpackage

// File: rtl/rr_pick_next.sv
// Combinational round-robin pick: first set req bit at or above ptr, wrapping 15->0.
module rr_pick_next
    import arb_pkg::*;
(
    input  logic [NREQ-1:0]  req,
    input  logic [SEL_W-1:0] ptr,
    output logic [SEL_W-1:0] pick,
    output logic             any
);

    logic [SEL_W-1:0] idx;

    // Walk offsets from the far end down so the nearest hit to ptr is written last.
    always_comb begin
        pick = '0;
        any  = 1'b0;
        idx  = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            idx = ptr + SEL_W'(i);
            if (req[idx]) begin
                pick = idx;
                any  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rr_decoder_arbiter.sv
// 16-way round-robin arbiter driving a 4-to-16 active-low-enable decoder; bounded tenures, one dead cycle between grants.
// Optional GRANT_LOCK_EN adds a lock input that extends a tenure past HOLD_MAX.
module rr_decoder_arbiter
    import arb_pkg::*;
#(
    parameter int HOLD_W   = 3,
    parameter int HOLD_MAX = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [NREQ-1:0]  req,
`ifdef GRANT_LOCK_EN
    input  logic             lock,
`endif
    output logic [SEL_W-1:0] sel,
    output logic             enable_n,
    output logic [NREQ-1:0]  grant,
    output logic             busy
);

    state_t           state;
    logic [HOLD_W-1:0] cnt;
    logic [SEL_W-1:0] ptr;
    logic [SEL_W-1:0] pick;
    logic             any;
    logic             lock_hold;
    logic             at_max;
    logic             rel;

    rr_pick_next u_pick (
        .req  (req),
        .ptr  (ptr),
        .pick (pick),
        .any  (any)
    );

`ifdef GRANT_LOCK_EN
    assign lock_hold = lock;
`else
    assign lock_hold = 1'b0;
`endif

    assign at_max = (cnt == HOLD_W'(HOLD_MAX));
    // A drop coinciding with expiry is one release, not two events.
    assign rel    = !req[sel] || (at_max && !lock_hold);

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            ptr      <= '0;
            sel      <= '0;
            enable_n <= 1'b1;
            grant    <= '0;
            busy     <= 1'b0;
        end else begin
            case (state)
                IDLE, GAP: begin
                    if (any) begin
                        state    <= GRANT;
                        sel      <= pick;
                        enable_n <= 1'b0;
                        grant    <= sel_onehot(pick);
                        cnt      <= HOLD_W'(1);
                        busy     <= 1'b1;
                    end else begin
                        state    <= IDLE;
                        enable_n <= 1'b1;
                        grant    <= '0;
                        busy     <= 1'b0;
                    end
                end
                GRANT: begin
                    if (rel) begin
                        state    <= GAP;
                        enable_n <= 1'b1;
                        grant    <= '0;
                        ptr      <= ptr_inc(sel);
                    end else if (!at_max) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    enable_n <= 1'b1;
                    grant    <= '0;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rr_decoder_arbiter.sv
// Scoreboard bench for rr_decoder_arbiter: directed phases plus random traffic against a tenure-level model.
// Define GRANT_LOCK_EN to also exercise the lock port.
module tb_rr_decoder_arbiter;

    localparam int HOLD_MAX = 4;

    typedef struct {
        logic [3:0]  sel;
        logic        enable_n;
        logic [15:0] grant;
        logic        busy;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] req = '0;
    logic        lock = 1'b0;
    logic [3:0]  sel;
    logic        enable_n;
    logic [15:0] grant;
    logic        busy;

    exp_t expq[$];
    int   n_checks = 0;
    int   n_errs = 0;

    // Reference model: who owns the resource, how long, and where the next scan starts.
    int m_owner = -1;
    bit m_gap   = 1'b0;
    int m_len   = 0;
    int m_ptr   = 0;
    int m_sel   = 0;

    always #5 clk = ~clk;

    rr_decoder_arbiter #(.HOLD_W(3), .HOLD_MAX(HOLD_MAX)) dut (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
`ifdef GRANT_LOCK_EN
        .lock     (lock),
`endif
        .sel      (sel),
        .enable_n (enable_n),
        .grant    (grant),
        .busy     (busy)
    );

    task automatic drive(input bit r, input logic [15:0] rq, input bit lk);
        exp_t e;
        bit   lk_eff;
        bit   done;
        @(negedge clk);
        reset = r;
        req   = rq;
        lock  = lk;
`ifdef GRANT_LOCK_EN
        lk_eff = lk;
`else
        lk_eff = 1'b0;
`endif
        if (r) begin
            m_owner = -1; m_gap = 0; m_len = 0; m_ptr = 0; m_sel = 0;
        end else if (m_owner >= 0) begin
            if (!rq[m_owner] || (m_len >= HOLD_MAX && !lk_eff)) begin
                m_ptr   = (m_owner + 1) % 16;
                m_owner = -1;
                m_gap   = 1'b1;
            end else if (m_len < HOLD_MAX) begin
                m_len++;
            end
        end else begin
            m_gap = 1'b0;
            done  = 1'b0;
            for (int k = 0; k < 16; k++) begin
                if (!done && rq[(m_ptr + k) % 16]) begin
                    m_owner = (m_ptr + k) % 16;
                    m_sel   = m_owner;
                    m_len   = 1;
                    done    = 1'b1;
                end
            end
        end
        e.sel      = 4'(m_sel);
        e.enable_n = (m_owner < 0);
        e.grant    = (m_owner >= 0) ? (16'h1 << m_owner) : 16'h0;
        e.busy     = (m_owner >= 0) || m_gap;
        expq.push_back(e);
    endtask

    // Monitor: one expected entry per rising edge, sampled just after it.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (expq.size() > 0) begin
                e = expq.pop_front();
                n_checks++;
                if (sel !== e.sel || enable_n !== e.enable_n || grant !== e.grant || busy !== e.busy) begin
                    n_errs++;
                    $display("FAIL outputs t=%0t: got sel=%0d en_n=%b grant=%h busy=%b, want sel=%0d en_n=%b grant=%h busy=%b",
                             $time, sel, enable_n, grant, busy, e.sel, e.enable_n, e.grant, e.busy);
                end
                n_checks++;
                if (!$onehot0(grant) || (enable_n && grant != 16'h0)) begin
                    n_errs++;
                    $display("FAIL grant_invariant t=%0t: got grant=%h en_n=%b, want one-hot-or-zero and zero when disabled",
                             $time, grant, enable_n);
                end
            end
        end
    end

    initial begin
        logic [15:0] rq;
        bit          lk;
        // Reset, then idle
        repeat (2) drive(1, 16'h0000, 0);
        repeat (5) drive(0, 16'h0000, 0);
        // Single requester: repeated tenures with gaps
        repeat (12) drive(0, 16'h0020, 0);
        repeat (3) drive(0, 16'h0000, 0);
        // All requesting: full rotation plus wrap
        repeat (16 * 5 + 6) drive(0, 16'hFFFF, 0);
        repeat (3) drive(0, 16'h0000, 0);
        // Park ptr at 15, then mid-tenure release with wrap to 0
        drive(1, 16'h0000, 0);
        repeat (2) drive(0, 16'h4000, 0);
        drive(0, 16'h0000, 0);
        repeat (3) drive(0, 16'h8001, 0);
        repeat (6) drive(0, 16'h0001, 0);
        repeat (3) drive(0, 16'h0000, 0);
        // Reset in the middle of a tenure of 9
        repeat (3) drive(0, 16'h0200, 0);
        drive(1, 16'h0200, 0);
        repeat (3) drive(0, 16'h0200, 0);
        repeat (3) drive(0, 16'h0000, 0);
`ifdef GRANT_LOCK_EN
        drive(1, 16'h0000, 0);
        repeat (12) drive(0, 16'h0003, 1);
        repeat (6) drive(0, 16'h0003, 0);
        repeat (3) drive(0, 16'h0000, 0);
`endif
        // Random traffic with sparse bit flips, occasional bursts and resets
        rq = 16'h0;
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 19) == 0) rq = 16'($urandom);
            else rq = rq ^ 16'($urandom & $urandom & $urandom);
            lk = ($urandom_range(0, 3) != 0);
            drive($urandom_range(0, 199) == 0, rq, lk);
        end
        repeat (3) drive(0, 16'h0000, 0);

        for (int k = 0; k < 10 && expq.size() > 0; k++) @(posedge clk);
        #2;
        if (expq.size() > 0) begin
            n_checks++;
            n_errs++;
            $display("FAIL drain: got %0d unchecked entries, want 0", expq.size());
        end
        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule

// File: doc/rr_decoder_arbiter.md
Name: rr_decoder_arbiter

Overview:
- 16-requester round-robin arbiter that time-shares one decoded resource.
- Produces a 4-bit select and an active-low enable, which feed the team's 4-to-16 active-low-enable decoder.
- Also provides a registered one-hot grant vector.
- Bounds each tenure with a hold limit and inserts one dead cycle between grants, so decoded outputs never overlap.

Parameters:
HOLD_W, 3, width of the hold counter
HOLD_MAX, 4, maximum consecutive GRANT cycles per tenure; legal range 1..(2**HOLD_W)-1

Ports:
clk  input  1  single clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
req  input  16  request lines; req[i] high = requester i wants the resource
lock  input  1  present only when GRANT_LOCK_EN is defined; holds the current tenure past HOLD_MAX
sel  output  4  index of granted requester; drives decoder address
enable_n  output  1  active-low enable for decoder; 0 only in GRANT
grant  output  16  one-hot grant; grant = enable_n ? 0 : (1 << sel)
busy  output  1  high when FSM is not IDLE

Behaviour:
- All outputs registered. Reset (synchronous, takes effect on the next edge, including mid-tenure) gives:
  - sel=0, enable_n=1, grant=0, busy=0
  - state=IDLE, hold counter=0, round-robin pointer ptr=0
- FSM states: IDLE, GRANT, GAP.
- IDLE:
  - If req==0, stay.
  - Otherwise pick the first set req bit scanning upward from ptr, wrapping 15->0.
  - Next edge: sel=pick, enable_n=0, counter=1, state=GRANT.
  - Latency req->grant = 1 cycle.
- GRANT (each cycle, evaluated against current sel):
  - req[sel]==0 -> next edge: GAP, enable_n=1, ptr=sel+1 (mod 16).
  - req[sel]==1 and counter==HOLD_MAX -> next edge: GAP, enable_n=1, ptr=sel+1 (mod 16).
  - Otherwise counter+1 and stay in GRANT.
  - One grant cycle may occur after req drops; requesters tolerate this.
- GAP: exactly one cycle, enable_n=1, sel holds its previous value.
  - Arbitration runs from ptr during GAP.
  - If any req is set -> GRANT with new pick (the same requester is allowed if it is the only one), counter=1.
  - Else -> IDLE.
- Fairness: with all 16 requesting continuously, grants cycle 0,1,...,15,0 with HOLD_MAX GRANT cycles plus 1 GAP cycle per tenure.
- Wrap-around: ptr=15 and granted 15 -> ptr becomes 0. Scan covers all 16 positions, so no requester is skipped.
- Simultaneous events:
  - New req bits arriving during GRANT do not preempt the current tenure.
  - A req dropping in the same cycle the counter hits HOLD_MAX is treated as a single release (same next state).
- Invariant: grant is one-hot or zero. grant is never nonzero while enable_n=1.

Optional Feature:
GRANT_LOCK_EN
- Defined: the lock port exists. In GRANT with req[sel]=1 and lock=1, HOLD_MAX expiry is ignored and the counter saturates at HOLD_MAX. Release occurs only when req[sel] drops or lock drops at counter==HOLD_MAX.
- Undefined: no lock port; the tenure always ends at HOLD_MAX.

Decomposition:
- Package arb_pkg:
  - NREQ=16 and SEL_W=4
  - state enum {IDLE, GRANT, GAP}
  - ptr increment-mod-16 helper function
- One sub-module, rr_pick_next: combinational; inputs req[15:0] and ptr[3:0]; outputs pick[3:0] and any.
- FSM, counter and output registers stay in the top module.

Test Plan:
- Reset, then req=16'h0000 for 5 cycles -> enable_n=1, grant=0, busy=0, sel=0 throughout.
- req=16'h0020 held -> 1 cycle later sel=5, grant=16'h0020. With HOLD_MAX=4: 4 GRANT cycles, 1 GAP (enable_n=1), then sel=5 granted again.
- req=16'hFFFF held -> grant sequence 0,1,2,...,15,0. Each tenure is 4 grant cycles followed by 1 gap. grant is never multi-hot.
- Mid-tenure release: start with ptr=15 and req=16'h8001. Grant 15; drop req[15] after 2 cycles -> 1 further grant cycle, then GAP, then sel=0 (wrap).
- Assert reset during GRANT of sel=9 -> next edge all outputs and ptr at reset values. After reset deasserts with req=16'h0200, grant of 9 follows one cycle later.
- GRANT_LOCK_EN defined, req=16'h0003, lock=1 on requester 0 for 10 cycles -> sel=0 held 10+ cycles. Drop lock -> GAP, then sel=1.
